// File: rtl/cr16_ctrl_fsm.sv
// Fetch/execute controller for the CR16 16-bit datapath: fetches over req/ack,
// decodes into ALU and register-file controls, keeps the PSR and sequences branches/LOAD/STOR.
module cr16_ctrl_fsm #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [3:0]  rf_raddr_a,
  output logic [3:0]  rf_raddr_b,
  input  logic [15:0] rf_rdata_a,
  input  logic [15:0] rf_rdata_b,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic [3:0]  alu_op,
  output logic [7:0]  alu_imm,
  output logic        alu_imm_en,
  output logic        alu_carry_in,
  input  logic [15:0] alu_out,
  input  logic [4:0]  alu_flags,
  output logic [4:0]  psr,
  output logic [15:0] pc
);

  localparam int unsigned DW = 16;
  localparam int unsigned FW = 5;

  typedef enum logic [1:0] {FETCH, EXEC, MEM} state_t;

  state_t          state;
  logic [DW-1:0]   ir;
  logic [3:0]      op, ext, cond;
  logic            is_rtype, is_itype, is_shift, is_alu;
  logic [3:0]      dec_op;
  logic            flag_upd, alu_wr;
  logic            is_bcond, is_jcond, is_jal, is_load, is_stor;
  logic            taken;
  logic [DW-1:0]   pc_inc, pc_disp;

  // Condition evaluation against the CLFZN flag register
  function automatic logic cond_met(input logic [3:0] c, input logic [FW-1:0] f);
    logic fc, fl, ff, fz, fn;
    {fc, fl, ff, fz, fn} = f;
    case (c)
      4'h0:    cond_met = fz;
      4'h1:    cond_met = !fz;
      4'h2:    cond_met = fc;
      4'h3:    cond_met = !fc;
      4'h4:    cond_met = fl;
      4'h5:    cond_met = !fl;
      4'h6:    cond_met = !fl && !fz;
      4'h7:    cond_met = fl || fz;
      4'h8:    cond_met = fn;
      4'h9:    cond_met = !fn;
      4'hA:    cond_met = !fn && !fz;
      4'hB:    cond_met = fn || fz;
      4'hC:    cond_met = ff;
      4'hD:    cond_met = !ff;
      4'hE:    cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  endfunction

  // Instruction decode from the latched IR
  always_comb begin
    op   = ir[15:12];
    ext  = ir[7:4];
    cond = ir[11:8];
    is_rtype = (op == 4'h0) && (ext inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                                            4'h7, 4'h9, 4'hA, 4'hB, 4'hD});
    is_itype = op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7,
                          4'h9, 4'hA, 4'hB, 4'hD, 4'hF};
    is_shift = (op == 4'h8);
    is_alu   = is_rtype || is_itype || is_shift;
    dec_op   = is_rtype ? ext : op;
    // MOV, LU and NOT are the only ALU ops that leave the flags alone
    flag_upd = is_alu && !(dec_op inside {4'h4, 4'hD, 4'hF});
    alu_wr   = is_alu && (dec_op != 4'hB);
    is_bcond = (op == 4'hC);
    is_jcond = (op == 4'h4) && (ext == 4'hC);
    is_jal   = (op == 4'h4) && (ext == 4'h8);
    is_load  = (op == 4'h4) && (ext == 4'h0);
    is_stor  = (op == 4'h4) && (ext == 4'h4);
    taken    = cond_met(cond, psr);
    pc_inc   = pc + DW'(1);
    pc_disp  = pc + {{8{ir[7]}}, ir[7:0]};
  end

  // Port drive; request and write strobes are killed as soon as reset rises
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = pc;
    mem_wdata    = rf_rdata_a;
    rf_we        = 1'b0;
    rf_wdata     = alu_out;
    rf_waddr     = ir[11:8];
    rf_raddr_a   = ir[11:8];
    rf_raddr_b   = ir[3:0];
    alu_op       = dec_op;
    alu_imm      = ir[7:0];
    alu_imm_en   = is_itype;
    alu_carry_in = psr[4];
    case (state)
      FETCH: mem_req = 1'b1;
      EXEC: begin
        rf_we    = alu_wr || is_jal;
        rf_wdata = is_jal ? pc_inc : alu_out;
      end
      MEM: begin
        mem_req  = 1'b1;
        mem_we   = is_stor;
        mem_addr = rf_rdata_b;
        if (is_load && mem_ack) begin
          rf_we    = 1'b1;
          rf_wdata = mem_rdata;
        end
      end
      default: ;
    endcase
    if (reset) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      rf_we   = 1'b0;
    end
  end

  // Control state, PC, IR and PSR
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
      psr   <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ack) begin
            ir    <= mem_rdata;
            state <= EXEC;
          end
        end
        EXEC: begin
          state <= FETCH;
          if (flag_upd) psr <= alu_flags;
          if (is_load || is_stor)          state <= MEM;
          else if (is_bcond && taken)      pc <= pc_disp;
          else if ((is_jcond && taken) || is_jal) pc <= rf_rdata_b;
          else                             pc <= pc_inc;
        end
        MEM: begin
          if (mem_ack) begin
            pc    <= pc_inc;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
